// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin / fixed-priority arbiter.
//   - arb_state_t : two-state grant FSM encoding (IDLE, GRANT)
//   - RR_N_REQ_DEFAULT / RR_IDX_W_DEFAULT : default requester count and the
//     grant-index width derived from it with $clog2
package rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int RR_N_REQ_DEFAULT = 4;
  localparam int RR_IDX_W_DEFAULT = (RR_N_REQ_DEFAULT > 1) ? $clog2(RR_N_REQ_DEFAULT) : 1;

endpackage

// File: rtl/rr_arbiter_select.sv
// rr_select: combinational masked priority pick.
// Picks one requester from req. One index can be masked out.
//   req        : request vector
//   last_ptr   : previous owner; round-robin scan starts at last_ptr+1
//   fixed_prio : 1 = lowest set index wins, 0 = round-robin from last_ptr+1
//   excl_en    : mask out excl_idx from the candidate set
//   excl_idx   : index to exclude (current owner on release/preemption)
//   sel        : one-hot pick (all zero when nothing is eligible)
//   sel_idx    : index of the pick (0 when nothing is eligible)
//   sel_valid  : an eligible requester exists
module rr_select
  import rr_arbiter_pkg::*;
#(
  parameter int N_REQ = RR_N_REQ_DEFAULT,
  parameter int IDX_W = RR_IDX_W_DEFAULT
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_ptr,
  input  logic             fixed_prio,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic [N_REQ-1:0] sel,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_valid
);

  logic [N_REQ-1:0] masked;
  logic [IDX_W-1:0] pos;

  always_comb begin
    masked = req;
    if (excl_en) begin
      masked[excl_idx] = 1'b0;
    end
  end

  // Linear scan in priority order. In round-robin mode the scan starts just
  // after the previous owner and wraps, so the previous owner is visited last.
  always_comb begin
    sel       = '0;
    sel_idx   = '0;
    sel_valid = 1'b0;
    pos       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (fixed_prio) begin
        pos = IDX_W'(i);
      end else begin
        pos = IDX_W'((int'(last_ptr) + 1 + i) % N_REQ);
      end
      if (!sel_valid && masked[pos]) begin
        sel_valid = 1'b1;
        sel[pos]  = 1'b1;
        sel_idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin / fixed-priority grant manager sharing
// one datapath unit between N_REQ requesters.
//   clk, rst    : clock, synchronous active-high reset
//   run         : one-cycle pulse, reinitialises arbitration state (like rst)
//   running     : new grants are only issued while high
//   fixed_prio  : 1 = lowest index wins, 0 = round-robin
//   req         : request vector, held high while the resource is needed
//   grant       : registered one-hot grant
//   grant_idx   : owner index (0 when no grant)
//   grant_valid : a grant is active
//   preempt     : one-cycle pulse when an owner is forced off by MAX_HOLD
//   state_dbg   : current FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake: a requester owns the resource from the first cycle grant[i]=1
// is seen until the cycle after it drops req[i]; grant only changes on clk.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N_REQ    = RR_N_REQ_DEFAULT,
  parameter int IDX_W    = RR_IDX_W_DEFAULT,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             running,
  input  logic             fixed_prio,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             preempt,
  output logic             state_dbg
);

  // Saturation point of the hold counter; with the limit disabled it just
  // counts up to its full range and stays there.
  localparam logic [CNT_W-1:0] HOLD_SAT   = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD) : '1;
  localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(N_REQ - 1);
  localparam logic             LIMIT_ON   = (MAX_HOLD > 0);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;

  logic [N_REQ-1:0] grant_d;
  logic [IDX_W-1:0] grant_idx_d;
  logic             grant_valid_d;
  logic             preempt_d;

  logic [N_REQ-1:0] sel;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;

  // While granted the owner is always excluded: on release its bit is
  // already low, and on preemption it must not win again.
  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_select (
    .req        (req),
    .last_ptr   (last_ptr_q),
    .fixed_prio (fixed_prio),
    .excl_en    (state_q == ST_GRANT),
    .excl_idx   (grant_idx),
    .sel        (sel),
    .sel_idx    (sel_idx),
    .sel_valid  (sel_valid)
  );

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    last_ptr_d    = last_ptr_q;
    grant_d       = grant;
    grant_idx_d   = grant_idx;
    grant_valid_d = grant_valid;
    preempt_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (running && sel_valid) begin
          state_d       = ST_GRANT;
          grant_d       = sel;
          grant_idx_d   = sel_idx;
          grant_valid_d = 1'b1;
          hold_cnt_d    = CNT_W'(1);
          last_ptr_d    = sel_idx;
        end
      end

      ST_GRANT: begin
        if (!req[grant_idx]) begin
          // Release: hand over directly when someone else waits.
          if (running && sel_valid) begin
            grant_d     = sel;
            grant_idx_d = sel_idx;
            hold_cnt_d  = CNT_W'(1);
            last_ptr_d  = sel_idx;
          end else begin
            state_d       = ST_IDLE;
            grant_d       = '0;
            grant_idx_d   = '0;
            grant_valid_d = 1'b0;
            hold_cnt_d    = '0;
          end
        end else if (LIMIT_ON && (hold_cnt_q == HOLD_SAT) && running && sel_valid) begin
          // Hold limit reached with another requester waiting: force handover.
          grant_d     = sel;
          grant_idx_d = sel_idx;
          hold_cnt_d  = CNT_W'(1);
          last_ptr_d  = sel_idx;
          preempt_d   = 1'b1;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d       = ST_IDLE;
        grant_d       = '0;
        grant_idx_d   = '0;
        grant_valid_d = 1'b0;
        hold_cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || run) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      last_ptr_q  <= PTR_RESET;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      last_ptr_q  <= last_ptr_d;
      grant       <= grant_d;
      grant_idx   <= grant_idx_d;
      grant_valid <= grant_valid_d;
      preempt     <= preempt_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N_REQ=4, MAX_HOLD=2). Each step drives one
// cycle of inputs, pushes the expected post-edge outputs, then pops and
// compares after the edge.
module tb_rr_arbiter;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int EW  = 1 + 1 + IW + N;   // {preempt, valid, idx, grant}

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          running;
  logic          fixed_prio;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          preempt;
  logic          state_dbg;

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  rr_arbiter #(
    .N_REQ    (N),
    .IDX_W    (IW),
    .MAX_HOLD (2),
    .CNT_W    (2)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .running     (running),
    .fixed_prio  (fixed_prio),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .preempt     (preempt),
    .state_dbg   (state_dbg)
  );

  function automatic logic [IW-1:0] idx_of(input logic [N-1:0] g);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) r = IW'(i);
    end
    return r;
  endfunction

  // driver + scoreboard: one clock cycle per call
  task automatic cyc(input string tag, input logic [N-1:0] r, input logic rn,
                     input logic fp, input logic rp,
                     input logic [N-1:0] eg, input logic ep);
    logic [EW-1:0] exp_v;
    logic [EW-1:0] obs_v;
    req        = r;
    running    = rn;
    fixed_prio = fp;
    run        = rp;
    exp_q.push_back({ep, |eg, idx_of(eg), eg});
    @(posedge clk);
    #1;
    obs_v = {preempt, grant_valid, grant_idx, grant};
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s observed p/v/idx/grant=%b expected=%b", tag, obs_v, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; running = 1'b0; fixed_prio = 1'b0; req = '0;
    @(negedge clk);

    // reset: outputs stay zero, even with requests present
    cyc("rst0", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc("rst1", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc("rst_req", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc("rst_run", 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
    rst = 1'b0;
    cyc("idle", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

    // basic grant then gapless handover
    cyc("basic_g1", 4'b0110, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0);
    cyc("basic_g2", 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0);
    cyc("basic_rel", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

    // fairness with MAX_HOLD=2, round-robin from index 0
    cyc("fair_run", 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
    cyc("fair0a", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    cyc("fair0b", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    cyc("fair1a", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1);
    cyc("fair1b", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0);
    cyc("fair2a", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1);
    cyc("fair2b", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0);
    cyc("fair3a", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1);
    cyc("fair3b", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0);
    cyc("fair0c", 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
    cyc("fair_rel", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

    // fixed priority
    cyc("fix_g1", 4'b1010, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0);
    cyc("fix_g3", 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0);
    cyc("fix_hold3", 4'b1010, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0);
    cyc("fix_pre1", 4'b1010, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1);
    cyc("fix_rel", 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);

    // lone holder: never preempted, grant steady
    for (int i = 0; i < 40; i++) begin
      cyc("lone", 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0);
    end
    cyc("lone_rel", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

    // abort mid-grant; pointer must be back at N_REQ-1
    cyc("abort_g", 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0);
    cyc("abort_run", 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
    cyc("abort_ptr", 4'b1001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    cyc("abort_rel", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

    // gating: no new grant while running=0
    for (int i = 0; i < 3; i++) begin
      cyc("gate_off", 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    end
    cyc("gate_on", 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    // running drops mid-grant: owner kept, no preemption, then idle
    cyc("stop_hold1", 4'b0011, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    cyc("stop_hold2", 4'b0011, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    cyc("stop_hold3", 4'b0011, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    cyc("stop_rel", 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc("stop_idle", 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc("restart", 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0);
    cyc("end_rel", 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
